lock_sequencer: RTL and testbench

- Top-level keypad controller for the digital lock. Consumes one-cycle debounced key events, runs the unlock and reprogram sequences, holds the stored passcode and decides whether it matches.
- Sits between the keypad/debounce front end and the lock actuator and LEDs.
- Performs the entry-length checks itself; it does not drive or depend on the length-checker block.

---
 rtl/lock_pkg.sv | 25 ++
 rtl/code_buffer.sv | 58 +++++
 rtl/lock_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_lock_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared key map and state encoding for the keypad lock sequencer.
package lock_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'd7;
  localparam logic [3:0] KEY_PROG  = 4'd8;
  localparam logic [3:0] KEY_ENTER = 4'd9;
  localparam logic [3:0] DIGIT_MAX = 4'd6;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ENTRY     = 3'd1;
  localparam logic [2:0] ST_PROG_OLD  = 3'd2;
  localparam logic [2:0] ST_PROG_NEW  = 3'd3;
  localparam logic [2:0] ST_PROG_CONF = 3'd4;
  localparam logic [2:0] ST_LOCKOUT   = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    ENTRY     = ST_ENTRY,
    PROG_OLD  = ST_PROG_OLD,
    PROG_NEW  = ST_PROG_NEW,
    PROG_CONF = ST_PROG_CONF,
    LOCKOUT   = ST_LOCKOUT
  } state_t;

endpackage

// File: rtl/code_buffer.sv
// Digit collector: indexed digit register, saturating count, overlong flag,
// and a length-plus-digits equality compare against a reference code.
module code_buffer
  import lock_pkg::*;
#(
  parameter int unsigned MAX_LEN = 5,
  localparam int unsigned LW = $clog2(MAX_LEN + 1),
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [3:0]               digit,
  input  logic                     load,
  input  logic [MAX_LEN-1:0][3:0]  load_code,
  input  logic [LW-1:0]            load_len,
  input  logic [MAX_LEN-1:0][3:0]  ref_code,
  input  logic [LW-1:0]            ref_len,
  output logic [MAX_LEN-1:0][3:0]  code,
  output logic [LW-1:0]            count,
  output logic                     overlong,
  output logic                     equal_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code     <= '0;
      count    <= '0;
      overlong <= 1'b0;
    end else if (load) begin
      code     <= load_code;
      count    <= load_len;
      overlong <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      overlong <= 1'b0;
    end else if (push) begin
      if (count == LW'(MAX_LEN)) begin
        overlong <= 1'b1;
      end else begin
        code[IW'(count)] <= digit;
        count            <= count + LW'(1);
      end
    end
  end

  // Digits above the count are stale and excluded from the compare.
  always_comb begin
    equal_c = (count == ref_len) && !overlong;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      if ((LW'(i) < count) && (code[IW'(i)] != ref_code[IW'(i)])) begin
        equal_c = 1'b0;
      end
    end
  end

endmodule

// File: rtl/lock_sequencer.sv
// Keypad lock controller: unlock/reprogram sequences, stored passcode,
// failed-attempt counting and timed lockout.
module lock_sequencer
  import lock_pkg::*;
#(
  parameter int unsigned         MAX_LEN      = 5,
  parameter int unsigned         MIN_LEN      = 3,
  parameter logic [4*MAX_LEN-1:0] DEFAULT_CODE = 20'h12345,
  parameter int unsigned         DEFAULT_LEN  = 5,
  parameter int unsigned         MAX_FAILS    = 3,
  parameter logic [23:0]         LOCKOUT_CYC  = 24'd12_000_000
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       unlocked,
  output logic       err_pulse,
  output logic       prog_ok,
  output logic       lockout,
  output logic       busy
);

  localparam int unsigned LW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);

  typedef logic [MAX_LEN-1:0][3:0] code_t;

  // DEFAULT_CODE is written in key order: its leading hex digit is the first key.
  function automatic code_t key_order(input code_t c);
    code_t r = '0;
    for (int i = 0; i < int'(DEFAULT_LEN); i++) begin
      r[IW'(i)] = c[IW'(int'(DEFAULT_LEN) - 1 - i)];
    end
    return r;
  endfunction

  localparam code_t RESET_CODE = key_order(DEFAULT_CODE);

  state_t          state, state_nx;
  logic [FW-1:0]   fail_cnt, fails_nx;
  logic [23:0]     timer;
  code_t           stored_code;
  logic [LW-1:0]   stored_len;

  code_t           entry_code, cand_code;
  logic [LW-1:0]   entry_count, cand_count;
  logic            entry_overlong, cand_overlong;
  logic            entry_eq, cand_eq;

  logic is_digit, is_clear, is_prog, is_enter, len_ok;
  logic entry_clear, entry_push, cand_load;
  logic match_ev, fail_ev, reject_ev, prog_ev;

  code_buffer #(.MAX_LEN(MAX_LEN)) u_entry (
    .clk      (hwclk),
    .rst      (rst),
    .clear    (entry_clear),
    .push     (entry_push),
    .digit    (key_code),
    .load     (1'b0),
    .load_code('0),
    .load_len ('0),
    .ref_code (stored_code),
    .ref_len  (stored_len),
    .code     (entry_code),
    .count    (entry_count),
    .overlong (entry_overlong),
    .equal_c  (entry_eq)
  );

  // Candidate new code, compared against the live confirm entry.
  code_buffer #(.MAX_LEN(MAX_LEN)) u_cand (
    .clk      (hwclk),
    .rst      (rst),
    .clear    (1'b0),
    .push     (1'b0),
    .digit    (4'd0),
    .load     (cand_load),
    .load_code(entry_code),
    .load_len (entry_count),
    .ref_code (entry_code),
    .ref_len  (entry_count),
    .code     (cand_code),
    .count    (cand_count),
    .overlong (cand_overlong),
    .equal_c  (cand_eq)
  );

  assign is_digit = key_valid && (key_code <= DIGIT_MAX);
  assign is_clear = key_valid && (key_code == KEY_CLEAR);
  assign is_prog  = key_valid && (key_code == KEY_PROG);
  assign is_enter = key_valid && (key_code == KEY_ENTER);
  assign len_ok   = !entry_overlong && (entry_count >= LW'(MIN_LEN))
                    && (entry_count <= LW'(MAX_LEN));

  // Next-state and event decode for the current key.
  always_comb begin
    state_nx    = state;
    fails_nx    = fail_cnt + FW'(1);
    entry_clear = 1'b0;
    entry_push  = 1'b0;
    cand_load   = 1'b0;
    match_ev    = 1'b0;
    fail_ev     = 1'b0;
    reject_ev   = 1'b0;
    prog_ev     = 1'b0;
    case (state)
      IDLE: begin
        if (is_enter) begin
          state_nx    = ENTRY;
          entry_clear = 1'b1;
        end else if (is_prog) begin
          state_nx    = PROG_OLD;
          entry_clear = 1'b1;
        end
      end
      ENTRY, PROG_OLD, PROG_NEW, PROG_CONF: begin
        if (is_digit) begin
          entry_push = 1'b1;
        end else if (is_clear) begin
          state_nx = IDLE;
        end else if (is_enter || is_prog) begin
          state_nx = IDLE;
          case (state)
            ENTRY: begin
              if (is_enter && entry_eq) match_ev = 1'b1;
              else                      fail_ev  = 1'b1;
            end
            PROG_OLD: begin
              if (is_prog && entry_eq) begin
                state_nx    = PROG_NEW;
                entry_clear = 1'b1;
              end else begin
                fail_ev = 1'b1;
              end
            end
            PROG_NEW: begin
              if (is_prog && len_ok) begin
                state_nx    = PROG_CONF;
                cand_load   = 1'b1;
                entry_clear = 1'b1;
              end else begin
                reject_ev = 1'b1;
              end
            end
            default: begin
              if (is_prog && cand_eq && !entry_overlong && !cand_overlong) prog_ev = 1'b1;
              else reject_ev = 1'b1;
            end
          endcase
          if (fail_ev && (fails_nx >= FW'(MAX_FAILS))) state_nx = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (timer == LOCKOUT_CYC - 24'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      unlocked    <= 1'b0;
      err_pulse   <= 1'b0;
      prog_ok     <= 1'b0;
      lockout     <= 1'b0;
      busy        <= 1'b0;
      fail_cnt    <= '0;
      timer       <= '0;
      stored_code <= RESET_CODE;
      stored_len  <= LW'(DEFAULT_LEN);
    end else begin
      state     <= state_nx;
      err_pulse <= fail_ev || reject_ev;
      prog_ok   <= prog_ev;
      lockout   <= (state_nx == LOCKOUT);
      busy      <= (state_nx != IDLE);
      if (match_ev) begin
        unlocked <= ~unlocked;
        fail_cnt <= '0;
      end
      if (fail_ev) fail_cnt <= fails_nx;
      if (prog_ev) begin
        stored_code <= cand_code;
        stored_len  <= cand_count;
        fail_cnt    <= '0;
      end
      if (state == LOCKOUT) begin
        if (timer == LOCKOUT_CYC - 24'd1) begin
          timer    <= '0;
          fail_cnt <= '0;
        end else begin
          timer <= timer + 24'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lock_sequencer.sv
// Randomized bench for lock_sequencer against a queue-based model of the
// unlock/program/lockout rules.
module tb_lock_sequencer;

  localparam int LC = 40;
  localparam int MAXL = 5;
  localparam int MINL = 3;
  localparam int MAXF = 3;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_OLD = 2, M_NEW = 3, M_CONF = 4, M_LOCK = 5;

  typedef int iq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       unlocked, err_pulse, prog_ok, lockout, busy;

  int n_vec = 0;
  int n_bad = 0;

  int   m_mode, m_fails, m_lock_left;
  bit   m_unl, m_err, m_prog;
  iq_t  entry_q, cand_q, stored_q;

  lock_sequencer #(.LOCKOUT_CYC(24'(LC))) dut (
    .hwclk    (clk),
    .rst      (rst),
    .key_valid(key_valid),
    .key_code (key_code),
    .unlocked (unlocked),
    .err_pulse(err_pulse),
    .prog_ok  (prog_ok),
    .lockout  (lockout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  function automatic bit same(input iq_t a, input iq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_mode = M_IDLE; m_fails = 0; m_lock_left = 0;
    m_unl = 0; m_err = 0; m_prog = 0;
    entry_q = {}; cand_q = {};
    stored_q = {1, 2, 3, 4, 5};
  endfunction

  function automatic void model_fail();
    m_err = 1;
    m_fails++;
    if (m_fails >= MAXF) begin m_mode = M_LOCK; m_lock_left = LC; end
    else m_mode = M_IDLE;
  endfunction

  function automatic void model_step(input bit kv, input int kc);
    m_err = 0; m_prog = 0;
    if (m_mode == M_LOCK) begin
      m_lock_left--;
      if (m_lock_left == 0) begin m_mode = M_IDLE; m_fails = 0; end
      return;
    end
    if (!kv || kc > 9) return;
    if (m_mode == M_IDLE) begin
      if (kc == 9) begin m_mode = M_ENTRY; entry_q = {}; end
      else if (kc == 8) begin m_mode = M_OLD; entry_q = {}; end
      return;
    end
    if (kc <= 6) begin entry_q.push_back(kc); return; end
    if (kc == 7) begin m_mode = M_IDLE; return; end
    case (m_mode)
      M_ENTRY:
        if (kc == 9 && same(entry_q, stored_q)) begin
          m_unl = !m_unl; m_fails = 0; m_mode = M_IDLE;
        end else model_fail();
      M_OLD:
        if (kc == 8 && same(entry_q, stored_q)) begin m_mode = M_NEW; entry_q = {}; end
        else model_fail();
      M_NEW:
        if (kc == 8 && entry_q.size() >= MINL && entry_q.size() <= MAXL) begin
          cand_q = entry_q; entry_q = {}; m_mode = M_CONF;
        end else begin m_err = 1; m_mode = M_IDLE; end
      default:
        if (kc == 8 && same(entry_q, cand_q)) begin
          stored_q = cand_q; m_prog = 1; m_fails = 0; m_mode = M_IDLE;
        end else begin m_err = 1; m_mode = M_IDLE; end
    endcase
  endfunction

  function automatic logic [4:0] exp_vec();
    return {m_unl, m_err, m_prog, m_mode == M_LOCK, m_mode != M_IDLE};
  endfunction

  // Random idle cycles (-1) inserted before keys.
  function automatic iq_t gapify(input iq_t s);
    iq_t o = {};
    foreach (s[i]) begin
      if ($urandom_range(0, 2) == 0) o.push_back(-1);
      o.push_back(s[i]);
    end
    return o;
  endfunction

  task automatic tick(input int k);
    @(negedge clk);
    key_valid = (k >= 0);
    key_code  = (k >= 0) ? 4'(k) : 4'd0;
    @(posedge clk);
    model_step(k >= 0, k);
    #1;
  endtask

  task automatic do_reset();
    key_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    key_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    got = {unlocked, err_pulse, prog_ok, lockout, busy};
    if (got !== 5'b0) begin n_bad++; $display("FAIL reset: outputs %b expected 00000", got); end
    n_vec++;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_unlock();
    iq_t s;
    logic [4:0] got;
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      s = gapify('{9, 1, 2, 3, 4, 5, 9});
      foreach (s[i]) begin
        tick(s[i]);
        got = {unlocked, err_pulse, prog_ok, lockout, busy};
        if (got !== exp_vec()) begin
          n_bad++; $display("FAIL unlock step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
        end
        n_vec++;
      end
      if (unlocked !== (rep == 0)) begin
        n_bad++; $display("FAIL unlock_toggle pass %0d: unlocked %b expected %b", rep, unlocked, rep == 0);
      end
      n_vec++;
    end
  endtask

  task automatic test_bad_unlock();
    iq_t s;
    logic [4:0] got;
    do_reset();
    s = gapify('{9, 1, 2, 3, 9, 9, 1, 2, 3, 4, 5, 6, 9});
    foreach (s[i]) begin
      tick(s[i]);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL bad_unlock step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
      end
      n_vec++;
    end
    if (err_pulse !== 1'b1 || unlocked !== 1'b0) begin
      n_bad++; $display("FAIL overlong: err_pulse %b unlocked %b expected 1 0", err_pulse, unlocked);
    end
    n_vec++;
  endtask

  task automatic test_program();
    iq_t s;
    logic [4:0] got;
    do_reset();
    s = gapify('{8, 1, 2, 3, 4, 5, 8, 6, 5, 4, 8, 6, 5, 4, 8});
    foreach (s[i]) begin
      tick(s[i]);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL program step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
      end
      n_vec++;
    end
    if (prog_ok !== 1'b1) begin n_bad++; $display("FAIL prog_ok: got %b expected 1", prog_ok); end
    n_vec++;
    s = gapify('{9, 6, 5, 4, 9, 9, 1, 2, 3, 4, 5, 9});
    foreach (s[i]) begin
      tick(s[i]);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL new_code step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
      end
      n_vec++;
    end
    if (err_pulse !== 1'b1 || unlocked !== 1'b1) begin
      n_bad++; $display("FAIL old_code_rejected: err_pulse %b unlocked %b expected 1 1", err_pulse, unlocked);
    end
    n_vec++;
  endtask

  task automatic test_prog_reject();
    iq_t s;
    logic [4:0] got;
    do_reset();
    s = gapify('{8, 1, 2, 3, 4, 5, 8, 6, 5, 4, 8, 6, 5, 3, 8,
                 8, 1, 2, 3, 4, 5, 8, 1, 2, 8,
                 9, 1, 2, 3, 4, 5, 9});
    foreach (s[i]) begin
      tick(s[i]);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL prog_reject step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
      end
      n_vec++;
    end
    if (unlocked !== 1'b1) begin n_bad++; $display("FAIL code_kept: unlocked %b expected 1", unlocked); end
    n_vec++;
  endtask

  task automatic test_lockout();
    iq_t s;
    logic [4:0] got;
    do_reset();
    s = gapify('{9, 1, 9, 9, 2, 9, 9, 3, 9});
    foreach (s[i]) begin
      tick(s[i]);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL lockout_entry step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
      end
      n_vec++;
    end
    if (lockout !== 1'b1) begin n_bad++; $display("FAIL lockout_set: lockout %b expected 1", lockout); end
    n_vec++;
    for (int c = 0; c < LC + 10 && (m_mode == M_LOCK || lockout === 1'b1); c++) begin
      tick((c < 8) ? int'($urandom_range(0, 15)) : -1);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL lockout_hold cycle %0d: got %b expected %b", c, got, exp_vec());
      end
      n_vec++;
    end
    s = gapify('{9, 1, 2, 3, 4, 5, 9});
    foreach (s[i]) begin
      tick(s[i]);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL lockout_exit step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
      end
      n_vec++;
    end
    if (unlocked !== 1'b1) begin n_bad++; $display("FAIL unlock_after_lockout: unlocked %b expected 1", unlocked); end
    n_vec++;
  endtask

  task automatic test_clear();
    iq_t s;
    logic [4:0] got;
    do_reset();
    s = gapify('{9, 1, 9, 9, 1, 2, 7, 8, 3, 7, 9, 1, 9});
    foreach (s[i]) begin
      tick(s[i]);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL clear step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
      end
      n_vec++;
    end
    if (lockout !== 1'b0) begin n_bad++; $display("FAIL clear_no_fail: lockout %b expected 0", lockout); end
    n_vec++;
  endtask

  task automatic test_rst_mid();
    iq_t s;
    logic [4:0] got;
    do_reset();
    s = gapify('{8, 1, 2, 3, 4, 5, 8, 6, 5, 4, 8, 6, 5, 4, 8, 8, 6, 5, 4, 8, 3, 3, 3, 8, 3});
    foreach (s[i]) begin
      tick(s[i]);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL rst_setup step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
      end
      n_vec++;
    end
    key_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    got = {unlocked, err_pulse, prog_ok, lockout, busy};
    if (got !== 5'b0) begin n_bad++; $display("FAIL rst_mid: outputs %b expected 00000", got); end
    n_vec++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    s = gapify('{9, 1, 2, 3, 4, 5, 9});
    foreach (s[i]) begin
      tick(s[i]);
      got = {unlocked, err_pulse, prog_ok, lockout, busy};
      if (got !== exp_vec()) begin
        n_bad++; $display("FAIL default_restored step %0d key %0d: got %b expected %b", i, s[i], got, exp_vec());
      end
      n_vec++;
    end
    if (unlocked !== 1'b1) begin n_bad++; $display("FAIL default_unlock: unlocked %b expected 1", unlocked); end
    n_vec++;
  endtask

  task automatic test_random();
    iq_t s, nc;
    logic [4:0] got;
    for (int it = 0; it < 300; it++) begin
      s = {};
      case ($urandom_range(0, 9))
        0, 1: begin
          s.push_back(9);
          foreach (stored_q[j]) s.push_back(stored_q[j]);
          s.push_back(9);
        end
        2: begin
          nc = {};
          for (int j = 0; j < int'($urandom_range(2, 6)); j++) nc.push_back(int'($urandom_range(0, 6)));
          s.push_back(8);
          foreach (stored_q[j]) s.push_back(stored_q[j]);
          s.push_back(8);
          foreach (nc[j]) s.push_back(nc[j]);
          s.push_back(8);
          if ($urandom_range(0, 3) == 0) nc[0] = (nc[0] + 1) % 7;
          foreach (nc[j]) s.push_back(nc[j]);
          s.push_back(8);
        end
        3, 4, 5: s.push_back(int'($urandom_range(0, 6)));
        default: s.push_back(int'($urandom_range(0, 15)));
      endcase
      s = gapify(s);
      foreach (s[i]) begin
        tick(s[i]);
        got = {unlocked, err_pulse, prog_ok, lockout, busy};
        if (got !== exp_vec()) begin
          n_bad++; $display("FAIL random iter %0d key %0d: got %b expected %b", it, s[i], got, exp_vec());
        end
        n_vec++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_unlock();
    test_bad_unlock();
    test_program();
    test_prog_reject();
    test_lockout();
    test_clear();
    test_rst_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
